// File: rtl/decode_branch_regfile.sv
// Decode-stage datapath: 16x32 register file, branch equality compare,
// and branch-offset generation from a 19-bit immediate.
module decode_branch_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Ra,
  input  logic [3:0]  Rb,
  input  logic [3:0]  Rd,
  input  logic        RWrite,
  input  logic        DataInputON,
  input  logic [31:0] DataInput,
  input  logic        Branch,
  input  logic [18:0] Imm,
  output logic [31:0] Data1,
  output logic [31:0] Data2,
  output logic [31:0] ImmExtend,
  output logic [31:0] BranchDir,
  output logic [3:0]  RD,
  output logic        PCSelect
);

  logic [31:0] regs [16];
  logic        eq;

  assign RD = RWrite ? Rd : Rb;

  // No bypass: reads see the stored value until the writing edge.
  assign Data1 = regs[Ra];
  assign Data2 = regs[Rb];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else if (DataInputON) begin
      regs[RD] <= DataInput;
    end
  end

  assign eq       = (Data1 == Data2);
  assign PCSelect = eq & Branch;

  assign ImmExtend = {{13{Imm[18]}}, Imm};
  assign BranchDir = {ImmExtend[29:0], 2'b00};

endmodule

// File: tb/tb_decode_branch_regfile.sv
// Self-checking bench for decode_branch_regfile: directed tables,
// multi-cycle corner sequences and random traffic against an array model.
module tb_decode_branch_regfile;

  logic        clk;
  logic        rst;
  logic [3:0]  Ra, Rb, Rd;
  logic        RWrite, DataInputON, Branch;
  logic [31:0] DataInput;
  logic [18:0] Imm;
  logic [31:0] Data1, Data2, ImmExtend, BranchDir;
  logic [3:0]  RD;
  logic        PCSelect;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [16];

  decode_branch_regfile dut (
    .clk(clk), .rst(rst),
    .Ra(Ra), .Rb(Rb), .Rd(Rd),
    .RWrite(RWrite), .DataInputON(DataInputON),
    .DataInput(DataInput), .Branch(Branch), .Imm(Imm),
    .Data1(Data1), .Data2(Data2),
    .ImmExtend(ImmExtend), .BranchDir(BranchDir),
    .RD(RD), .PCSelect(PCSelect)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: higher-level view of the block from its rules.
  task automatic check_all(input string tag);
    logic signed [31:0] ext;
    logic [3:0] wa;
    ext = $signed(Imm);
    wa  = RWrite ? Rd : Rb;
    chk({tag, ".Data1"}, Data1, model[Ra]);
    chk({tag, ".Data2"}, Data2, model[Rb]);
    chk({tag, ".RD"}, {28'd0, RD}, {28'd0, wa});
    chk({tag, ".ImmExtend"}, ImmExtend, ext);
    chk({tag, ".BranchDir"}, BranchDir, ext * 4);
    chk({tag, ".PCSelect"}, {31'd0, PCSelect},
        {31'd0, Branch && (model[Ra] == model[Rb])});
  endtask

  // One rising edge; model commits the write the DUT should perform.
  task automatic tick();
    @(posedge clk);
    if (!rst && DataInputON)
      model[RWrite ? Rd : Rb] = DataInput;
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    RWrite = 1; Rd = a; DataInput = d; DataInputON = 1;
    tick();
    DataInputON = 0;
  endtask

  typedef struct {
    logic [18:0] imm;
    logic [31:0] ext;
    logic [31:0] dir;
  } imm_vec_t;

  imm_vec_t imm_tab [6];

  initial begin
    imm_tab[0] = '{19'h00003, 32'h00000003, 32'h0000000C};
    imm_tab[1] = '{19'h7FFFF, 32'hFFFFFFFF, 32'hFFFFFFFC};
    imm_tab[2] = '{19'h40000, 32'hFFFC0000, 32'hFFF00000};
    imm_tab[3] = '{19'h3FFFF, 32'h0003FFFF, 32'h000FFFFC};
    imm_tab[4] = '{19'h00000, 32'h00000000, 32'h00000000};
    imm_tab[5] = '{19'h20001, 32'h00020001, 32'h00080004};

    for (int i = 0; i < 16; i++) model[i] = '0;
    rst = 0; Ra = 0; Rb = 0; Rd = 0; RWrite = 0;
    DataInputON = 0; DataInput = 0; Branch = 0; Imm = 0;

    // Power-on reset
    #2 rst = 1;
    #2;
    chk("reset.Data1", Data1, 32'h0);
    chk("reset.Data2", Data2, 32'h0);
    @(negedge clk);
    rst = 0;
    #1;

    // Write via Rd, and no bypass before the edge
    RWrite = 1; Rd = 5; Ra = 5;
    DataInput = 32'hDEADBEEF; DataInputON = 1;
    #1 chk("nobypass.Data1", Data1, 32'h0);
    tick();
    DataInputON = 0;
    chk("wr_rd.Data1", Data1, 32'hDEADBEEF);

    // Write via Rb
    RWrite = 0; Rb = 9; DataInput = 32'h12345678; DataInputON = 1;
    #1 chk("wr_rb.RD", {28'd0, RD}, 32'd9);
    tick();
    DataInputON = 0;
    chk("wr_rb.Data2", Data2, 32'h12345678);

    // Write enable low
    DataInput = 32'hFFFFFFFF; Rd = 9; RWrite = 1;
    tick();
    chk("we_off.Data2", Data2, 32'h12345678);
    check_all("we_off");

    // Branch compare
    write_reg(1, 32'd7);
    write_reg(2, 32'd7);
    Ra = 1; Rb = 2; Branch = 1;
    #1 chk("br_eq.PCSelect", {31'd0, PCSelect}, 32'd1);
    Branch = 0;
    #1 chk("br_off.PCSelect", {31'd0, PCSelect}, 32'd0);
    Branch = 1;
    write_reg(2, 32'd8);
    chk("br_ne.PCSelect", {31'd0, PCSelect}, 32'd0);
    write_reg(2, 32'h80000007);
    chk("br_msb.PCSelect", {31'd0, PCSelect}, 32'd0);
    Branch = 0;

    // Immediate table
    for (int i = 0; i < 6; i++) begin
      Imm = imm_tab[i].imm;
      #1;
      chk($sformatf("imm%0d.ImmExtend", i), ImmExtend, imm_tab[i].ext);
      chk($sformatf("imm%0d.BranchDir", i), BranchDir, imm_tab[i].dir);
    end

    // All registers, both ports
    for (int i = 0; i < 16; i++)
      write_reg(4'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 16; i++) begin
      Ra = 4'(i); Rb = 4'(15 - i);
      #1;
      chk($sformatf("all.Data1[%0d]", i), Data1, 32'(i) * 32'h01010101);
      chk($sformatf("all.Data2[%0d]", 15 - i), Data2,
          32'(15 - i) * 32'h01010101);
    end

    // Asynchronous reset mid-cycle with preloaded registers
    Ra = 3; Rb = 4; Branch = 1;
    #2 rst = 1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    #1;
    chk("arst.Data1", Data1, 32'h0);
    chk("arst.Data2", Data2, 32'h0);
    chk("arst.PCSelect", {31'd0, PCSelect}, 32'd1);
    RWrite = 1; Rd = 3; DataInput = 32'hAAAA5555; DataInputON = 1;
    tick();
    chk("arst_wr.Data1", Data1, 32'h0);
    DataInputON = 0;
    rst = 0;
    #1;
    check_all("post_rst");

    // Random traffic; small data pool makes equal compares likely
    for (int n = 0; n < 400; n++) begin
      Ra = 4'($urandom_range(0, 15));
      Rb = ($urandom_range(0, 3) == 0) ? Ra : 4'($urandom_range(0, 15));
      Rd = 4'($urandom_range(0, 15));
      RWrite = 1'($urandom_range(0, 1));
      DataInputON = 1'($urandom_range(0, 1));
      DataInput = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3))
                                              : $urandom;
      Branch = 1'($urandom_range(0, 1));
      Imm = 19'($urandom);
      #1;
      check_all($sformatf("rnd%0d", n));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
